// File: rtl/csr_access_ctrl_if.sv
// Core-side request/response channel of the CSR access controller.
// master = decode/execute stage, slave = csr_access_ctrl.
interface csr_access_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_op;
    logic [11:0]     in_addr;
    logic [XLEN-1:0] in_src;
    logic            in_nowr;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic            out_rd_wen;
    logic [XLEN-1:0] out_rd_wdata;
    logic            out_redir;
    logic [XLEN-1:0] out_redir_pc;

    modport master (
        output in_valid, in_op, in_addr, in_src, in_nowr, in_pc, out_ready,
        input  in_ready, out_valid, out_rd_wen, out_rd_wdata, out_redir, out_redir_pc
    );

    modport slave (
        input  in_valid, in_op, in_addr, in_src, in_nowr, in_pc, out_ready,
        output in_ready, out_valid, out_rd_wen, out_rd_wdata, out_redir, out_redir_pc
    );
endinterface

// File: rtl/csr_access_ctrl.sv
// Machine-mode CSR access sequencer: Zicsr read-modify-write, ECALL trap
// entry and MRET, handed to the core over a valid/ready response.
// Optional build macro CSR_ILLEGAL_TRAP_EN: reserved ops and CSR ops to
// unimplemented addresses raise an illegal-instruction trap.
module csr_access_ctrl #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned CAUSE_ECALL   = 11,
    parameter int unsigned CAUSE_ILLEGAL = 2
) (
    input  logic              clk,
    input  logic              rst,
    csr_access_ctrl_if.slave  core,
    output logic [11:0]       csr_raddr,
    input  logic [XLEN-1:0]   csr_rdata,
    output logic              csr_wen,
    output logic [11:0]       csr_waddr,
    output logic [XLEN-1:0]   csr_wdata,
    output logic              exc_en,
    output logic [XLEN-1:0]   exc_mepc,
    output logic [XLEN-1:0]   exc_mcause,
    input  logic [XLEN-1:0]   mtvec_rdata,
    input  logic [XLEN-1:0]   mepc_rdata
);
    localparam logic [2:0] OP_RW    = 3'd0;
    localparam logic [2:0] OP_RS    = 3'd1;
    localparam logic [2:0] OP_RC    = 3'd2;
    localparam logic [2:0] OP_ECALL = 3'd3;
    localparam logic [2:0] OP_MRET  = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state;
    logic [2:0]      r_op;
    logic [11:0]     r_addr;
    logic [XLEN-1:0] r_src;
    logic            r_nowr;
    logic [XLEN-1:0] r_pc;

    logic            r_out_valid;
    logic            r_rd_wen;
    logic [XLEN-1:0] r_rd_wdata;
    logic            r_redir;
    logic [XLEN-1:0] r_redir_pc;

    logic            w_exec;
    logic            w_csr_op;
    logic            w_set_clr;
    logic            w_illegal;
    logic            w_trap;
    logic [XLEN-1:0] w_new;

    assign core.in_ready     = (r_state == S_IDLE);
    assign core.out_valid    = r_out_valid;
    assign core.out_rd_wen   = r_rd_wen;
    assign core.out_rd_wdata = r_rd_wdata;
    assign core.out_redir    = r_redir;
    assign core.out_redir_pc = r_redir_pc;

    // EXEC-cycle CSR read/write and trap strobes; all zero outside EXEC.
    // Gating with rst keeps a write pending at the reset edge from landing.
    always_comb begin
        w_exec    = (r_state == S_EXEC) && !rst;
        w_csr_op  = (r_op <= OP_RC);
        w_set_clr = (r_op == OP_RS) || (r_op == OP_RC);
`ifdef CSR_ILLEGAL_TRAP_EN
        w_illegal = (r_op > OP_MRET) ||
                    (w_csr_op && !((r_addr == 12'h300) || (r_addr == 12'h305) ||
                                   (r_addr == 12'h341) || (r_addr == 12'h342)));
`else
        w_illegal = 1'b0;
`endif
        w_trap = (r_op == OP_ECALL) || w_illegal;

        case (r_op)
            OP_RW:   w_new = r_src;
            OP_RS:   w_new = csr_rdata | r_src;
            OP_RC:   w_new = csr_rdata & ~r_src;
            default: w_new = '0;
        endcase

        csr_raddr  = '0;
        csr_wen    = 1'b0;
        csr_waddr  = '0;
        csr_wdata  = '0;
        exc_en     = 1'b0;
        exc_mepc   = '0;
        exc_mcause = '0;
        if (w_exec) begin
            if (w_csr_op && !w_illegal) begin
                csr_raddr = r_addr;
                if (!(w_set_clr && r_nowr)) begin
                    csr_wen   = 1'b1;
                    csr_waddr = r_addr;
                    csr_wdata = w_new;
                end
            end
            if (w_trap) begin
                exc_en     = 1'b1;
                exc_mepc   = r_pc;
                exc_mcause = (r_op == OP_ECALL) ? XLEN'(CAUSE_ECALL) : XLEN'(CAUSE_ILLEGAL);
            end
        end
    end

    // Request latch, EXEC->RESP result capture and response hold until out_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_addr      <= '0;
            r_src       <= '0;
            r_nowr      <= 1'b0;
            r_pc        <= '0;
            r_out_valid <= 1'b0;
            r_rd_wen    <= 1'b0;
            r_rd_wdata  <= '0;
            r_redir     <= 1'b0;
            r_redir_pc  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (core.in_valid) begin
                        r_op    <= core.in_op;
                        r_addr  <= core.in_addr;
                        r_src   <= core.in_src;
                        r_nowr  <= core.in_nowr;
                        r_pc    <= core.in_pc;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_out_valid <= 1'b1;
                    r_rd_wen    <= w_csr_op && !w_illegal;
                    r_rd_wdata  <= (w_csr_op && !w_illegal) ? csr_rdata : '0;
                    r_redir     <= w_trap || (r_op == OP_MRET);
                    r_redir_pc  <= w_trap ? mtvec_rdata :
                                   ((r_op == OP_MRET) ? mepc_rdata : '0);
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (core.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_rd_wen    <= 1'b0;
                        r_rd_wdata  <= '0;
                        r_redir     <= 1'b0;
                        r_redir_pc  <= '0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_csr_access_ctrl.sv
// Directed bench for csr_access_ctrl with a small four-register CSR file
// (mstatus/mtvec/mepc/mcause) as the environment.
module tb_csr_access_ctrl;
    localparam int unsigned XLEN = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    csr_access_ctrl_if #(.XLEN(XLEN)) core_if ();

    logic [11:0]     csr_raddr;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_wen;
    logic [11:0]     csr_waddr;
    logic [XLEN-1:0] csr_wdata;
    logic            exc_en;
    logic [XLEN-1:0] exc_mepc;
    logic [XLEN-1:0] exc_mcause;
    logic [XLEN-1:0] mtvec_rdata;
    logic [XLEN-1:0] mepc_rdata;

    csr_access_ctrl #(.XLEN(XLEN), .CAUSE_ECALL(11), .CAUSE_ILLEGAL(2)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .core        (core_if.slave),
        .csr_raddr   (csr_raddr),
        .csr_rdata   (csr_rdata),
        .csr_wen     (csr_wen),
        .csr_waddr   (csr_waddr),
        .csr_wdata   (csr_wdata),
        .exc_en      (exc_en),
        .exc_mepc    (exc_mepc),
        .exc_mcause  (exc_mcause),
        .mtvec_rdata (mtvec_rdata),
        .mepc_rdata  (mepc_rdata)
    );

    // CSR file environment
    logic            model_init = 1'b1;
    logic [31:0]     m_mstatus, m_mtvec, m_mepc, m_mcause;
    int unsigned     wen_total = 0;
    int unsigned     exc_total = 0;
    logic [31:0]     seen_wdata, seen_mepc, seen_mcause;
    logic [11:0]     seen_waddr;

    always_comb begin
        case (csr_raddr)
            12'h300: csr_rdata = m_mstatus;
            12'h305: csr_rdata = m_mtvec;
            12'h341: csr_rdata = m_mepc;
            12'h342: csr_rdata = m_mcause;
            default: csr_rdata = '0;
        endcase
    end
    assign mtvec_rdata = m_mtvec;
    assign mepc_rdata  = m_mepc;

    always @(posedge clk) begin
        if (model_init) begin
            m_mstatus   <= '0;
            m_mtvec     <= '0;
            m_mepc      <= '0;
            m_mcause    <= '0;
            seen_wdata  <= '0;
            seen_waddr  <= '0;
            seen_mepc   <= '0;
            seen_mcause <= '0;
        end else begin
            if (csr_wen) begin
                wen_total  <= wen_total + 1;
                seen_wdata <= csr_wdata;
                seen_waddr <= csr_waddr;
                case (csr_waddr)
                    12'h300: m_mstatus <= csr_wdata;
                    12'h305: m_mtvec   <= csr_wdata;
                    12'h341: m_mepc    <= csr_wdata;
                    12'h342: m_mcause  <= csr_wdata;
                    default: ;
                endcase
            end
            if (exc_en) begin
                exc_total   <= exc_total + 1;
                seen_mepc   <= exc_mepc;
                seen_mcause <= exc_mcause;
                m_mepc      <= exc_mepc;
                m_mcause    <= exc_mcause;
            end
        end
    end

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Response capture of the last issued operation
    logic        c_rd_wen, c_redir;
    logic [31:0] c_rd_wdata, c_redir_pc;
    int unsigned c_lat, d_wen, d_exc;

    task automatic issue(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] src,
                         input logic nowr, input logic [31:0] pc, input int unsigned hold);
        int unsigned w0, e0;
        logic        got;
        @(negedge clk);
        chk("in_ready_idle", 32'(core_if.in_ready), 32'd1);
        w0 = wen_total;
        e0 = exc_total;
        core_if.in_valid  = 1'b1;
        core_if.in_op     = op;
        core_if.in_addr   = addr;
        core_if.in_src    = src;
        core_if.in_nowr   = nowr;
        core_if.in_pc     = pc;
        core_if.out_ready = (hold == 0);
        got   = 1'b0;
        c_lat = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            core_if.in_valid = 1'b0;
            c_lat++;
            if (core_if.out_valid) got = 1'b1;
        end
        chk("resp_seen", 32'(got), 32'd1);
        c_rd_wen   = core_if.out_rd_wen;
        c_rd_wdata = core_if.out_rd_wdata;
        c_redir    = core_if.out_redir;
        c_redir_pc = core_if.out_redir_pc;
        for (int k = 0; k < int'(hold); k++) begin
            @(negedge clk);
            chk("hold_valid", 32'(core_if.out_valid), 32'd1);
            chk("hold_in_ready", 32'(core_if.in_ready), 32'd0);
            chk("hold_rd_wdata", core_if.out_rd_wdata, c_rd_wdata);
            chk("hold_redir_pc", core_if.out_redir_pc, c_redir_pc);
        end
        core_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("valid_drop", 32'(core_if.out_valid), 32'd0);
        core_if.out_ready = 1'b0;
        d_wen = wen_total - w0;
        d_exc = exc_total - e0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        core_if.in_valid  = 1'b0;
        core_if.in_op     = '0;
        core_if.in_addr   = '0;
        core_if.in_src    = '0;
        core_if.in_nowr   = 1'b0;
        core_if.in_pc     = '0;
        core_if.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(core_if.in_ready), 32'd1);
        chk("rst_out_valid", 32'(core_if.out_valid), 32'd0);
        chk("rst_csr_wen", 32'(csr_wen), 32'd0);
        chk("rst_exc_en", 32'(exc_en), 32'd0);
        chk("rst_redir_pc", core_if.out_redir_pc, 32'd0);
        rst = 1'b0;
        model_init = 1'b0;

        // CSRRW mtvec
        issue(3'd0, 12'h305, 32'h8000_0100, 1'b0, 32'h8000_0000, 0);
        chk("rw_latency", c_lat, 32'd2);
        chk("rw_wen_cnt", d_wen, 32'd1);
        chk("rw_wdata", seen_wdata, 32'h8000_0100);
        chk("rw_waddr", 32'(seen_waddr), 32'h305);
        chk("rw_rd_wen", 32'(c_rd_wen), 32'd1);
        chk("rw_rd_wdata", c_rd_wdata, 32'h0);
        chk("rw_redir", 32'(c_redir), 32'd0);
        chk("rw_mtvec", mtvec_rdata, 32'h8000_0100);

        // mstatus preload, set, clear
        issue(3'd0, 12'h300, 32'h0000_1800, 1'b0, 32'h8000_0004, 0);
        chk("pre_rd_wdata", c_rd_wdata, 32'h0);
        issue(3'd1, 12'h300, 32'h0000_0008, 1'b0, 32'h8000_0008, 0);
        chk("rs_wdata", seen_wdata, 32'h0000_1808);
        chk("rs_rd_wdata", c_rd_wdata, 32'h0000_1800);
        issue(3'd2, 12'h300, 32'h0000_1000, 1'b0, 32'h8000_000C, 0);
        chk("rc_wdata", seen_wdata, 32'h0000_0808);
        chk("rc_rd_wdata", c_rd_wdata, 32'h0000_1808);
        chk("rc_mstatus", m_mstatus, 32'h0000_0808);

        // ECALL
        issue(3'd3, 12'h000, 32'h0, 1'b0, 32'h8000_0040, 0);
        chk("ecall_exc_cnt", d_exc, 32'd1);
        chk("ecall_wen_cnt", d_wen, 32'd0);
        chk("ecall_mepc", seen_mepc, 32'h8000_0040);
        chk("ecall_mcause", seen_mcause, 32'd11);
        chk("ecall_redir", 32'(c_redir), 32'd1);
        chk("ecall_redir_pc", c_redir_pc, 32'h8000_0100);
        chk("ecall_rd_wen", 32'(c_rd_wen), 32'd0);

        // CSRRS mcause with nowr: pure read
        issue(3'd1, 12'h342, 32'h0, 1'b1, 32'h8000_0100, 0);
        chk("rsnw_wen_cnt", d_wen, 32'd0);
        chk("rsnw_rd_wen", 32'(c_rd_wen), 32'd1);
        chk("rsnw_rd_wdata", c_rd_wdata, 32'd11);

        // MRET
        issue(3'd4, 12'h000, 32'h0, 1'b0, 32'h8000_0104, 0);
        chk("mret_redir", 32'(c_redir), 32'd1);
        chk("mret_redir_pc", c_redir_pc, 32'h8000_0040);
        chk("mret_wen_cnt", d_wen, 32'd0);
        chk("mret_exc_cnt", d_exc, 32'd0);

        // mepc write immediately used by MRET
        issue(3'd0, 12'h341, 32'h8000_0200, 1'b0, 32'h8000_0044, 0);
        chk("wmepc_rd_wdata", c_rd_wdata, 32'h8000_0040);
        issue(3'd4, 12'h000, 32'h0, 1'b0, 32'h8000_0048, 0);
        chk("mret2_redir_pc", c_redir_pc, 32'h8000_0200);

        // Reserved op
        issue(3'd5, 12'h300, 32'hFFFF_FFFF, 1'b0, 32'h8000_0050, 0);
        chk("rsv_wen_cnt", d_wen, 32'd0);
        chk("rsv_rd_wen", 32'(c_rd_wen), 32'd0);
`ifdef CSR_ILLEGAL_TRAP_EN
        chk("rsv_exc_cnt", d_exc, 32'd1);
        chk("rsv_mcause", seen_mcause, 32'd2);
        chk("rsv_redir", 32'(c_redir), 32'd1);
        chk("rsv_redir_pc", c_redir_pc, 32'h8000_0100);
`else
        chk("rsv_exc_cnt", d_exc, 32'd0);
        chk("rsv_redir", 32'(c_redir), 32'd0);
        chk("rsv_mstatus", m_mstatus, 32'h0000_0808);
`endif

        // Stall response for 5 cycles
        issue(3'd1, 12'h300, 32'h0, 1'b1, 32'h8000_0060, 5);
        chk("stall_rd_wdata", c_rd_wdata, 32'h0000_0808);

        // Reset while a CSRRW sits in EXEC
        begin
            int unsigned w0;
            @(negedge clk);
            w0 = wen_total;
            core_if.in_valid = 1'b1;
            core_if.in_op    = 3'd0;
            core_if.in_addr  = 12'h300;
            core_if.in_src   = 32'hDEAD_BEEF;
            core_if.in_nowr  = 1'b0;
            core_if.in_pc    = 32'h8000_0070;
            @(negedge clk);
            core_if.in_valid = 1'b0;
            chk("exec_in_ready", 32'(core_if.in_ready), 32'd0);
            rst = 1'b1;
            @(negedge clk);
            chk("rstx_in_ready", 32'(core_if.in_ready), 32'd1);
            chk("rstx_out_valid", 32'(core_if.out_valid), 32'd0);
            chk("rstx_wen_cnt", wen_total - w0, 32'd0);
            chk("rstx_mstatus", m_mstatus, 32'h0000_0808);
            rst = 1'b0;
        end
        issue(3'd1, 12'h300, 32'h0, 1'b1, 32'h8000_0074, 0);
        chk("post_rst_rd_wdata", c_rd_wdata, 32'h0000_0808);

        // Access to an unimplemented CSR
        issue(3'd0, 12'h7C0, 32'h1234_5678, 1'b0, 32'h8000_0010, 0);
`ifdef CSR_ILLEGAL_TRAP_EN
        chk("ill_wen_cnt", d_wen, 32'd0);
        chk("ill_exc_cnt", d_exc, 32'd1);
        chk("ill_mcause", seen_mcause, 32'd2);
        chk("ill_mepc", seen_mepc, 32'h8000_0010);
        chk("ill_rd_wen", 32'(c_rd_wen), 32'd0);
        chk("ill_redir_pc", c_redir_pc, 32'h8000_0100);
`else
        chk("unk_wen_cnt", d_wen, 32'd1);
        chk("unk_exc_cnt", d_exc, 32'd0);
        chk("unk_rd_wen", 32'(c_rd_wen), 32'd1);
        chk("unk_rd_wdata", c_rd_wdata, 32'h0);
        chk("unk_redir", 32'(c_redir), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
